// File: rtl/v_vram_resp_if.sv
// VRAM responder bus: core read/write port, 4-phase host port, status.
// Master drives requests, slave (the responder) returns data, ack and counters.
interface v_vram_resp_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              vram_r_ena;
  logic [ADDR_W-1:0] vram_r_addr;
  logic [DATA_W-1:0] vram_r_data;
  logic              vram_w_ena;
  logic [ADDR_W-1:0] vram_w_addr;
  logic [DATA_W-1:0] vram_w_data;
  logic [DATA_W-1:0] vram_w_mask;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              addr_err;

  modport master (
    output vram_r_ena, vram_r_addr, vram_w_ena, vram_w_addr, vram_w_data, vram_w_mask,
    output host_req, host_we, host_addr, host_wdata,
    input  vram_r_data, host_ack, host_rdata, rd_cnt, wr_cnt, addr_err
  );

  modport slave (
    input  vram_r_ena, vram_r_addr, vram_w_ena, vram_w_addr, vram_w_data, vram_w_mask,
    input  host_req, host_we, host_addr, host_wdata,
    output vram_r_data, host_ack, host_rdata, rd_cnt, wr_cnt, addr_err
  );
endinterface

// File: rtl/v_vram_resp.sv
// VRAM responder: zero-latency core reads, bit-masked core writes on the edge, host port
// served only while the core is idle (core is never stalled; host waits indefinitely).
module v_vram_resp #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  v_vram_resp_if.slave    bus
);

  localparam int                OFF_W   = $clog2(DATA_W / 8);
  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q;
  state_t            state_d;

  logic              h_we_q;
  logic [ADDR_W-1:0] h_addr_q;
  logic [DATA_W-1:0] h_wdata_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic              addr_err_q;

  logic [ADDR_W-1:0] r_word;
  logic [ADDR_W-1:0] w_word;
  logic [ADDR_W-1:0] h_word;
  logic              r_in;
  logic              w_in;
  logic              h_in;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  h_idx;

  logic              core_busy;
  logic              capture;
  logic              h_go;
  logic              ack_c;
  logic              core_wr_go;
  logic              host_wr_go;
  logic              err_set;

  // Word index is the byte address with the in-word offset dropped; range test uses the full width
  // so addresses beyond DEPTH never alias onto low words.
  assign r_word = bus.vram_r_addr >> OFF_W;
  assign w_word = bus.vram_w_addr >> OFF_W;
  assign h_word = h_addr_q >> OFF_W;
  assign r_in   = r_word < DEPTH_A;
  assign w_in   = w_word < DEPTH_A;
  assign h_in   = h_word < DEPTH_A;
  assign r_idx  = r_word[IDX_W-1:0];
  assign w_idx  = w_word[IDX_W-1:0];
  assign h_idx  = h_word[IDX_W-1:0];

  assign core_busy  = bus.vram_r_ena | bus.vram_w_ena;
  assign core_wr_go = bus.vram_w_ena & w_in;
  assign host_wr_go = h_go & h_we_q & h_in;
  assign err_set    = (bus.vram_r_ena & ~r_in) | (bus.vram_w_ena & ~w_in) | (h_go & ~h_in);

  assign bus.vram_r_data = (bus.vram_r_ena && r_in) ? mem[r_idx] : '0;
  assign bus.host_ack    = ack_c;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.rd_cnt      = rd_cnt_q;
  assign bus.wr_cnt      = wr_cnt_q;
  assign bus.addr_err    = addr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.host_req) state_d = REQ;
      REQ:     if (!core_busy) state_d = ACK;
      ACK:     state_d = DONE;
      DONE:    if (!bus.host_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    h_go    = 1'b0;
    ack_c   = 1'b0;
    unique case (state_q)
      IDLE:    capture = bus.host_req;
      REQ:     h_go    = ~core_busy;
      ACK:     ack_c   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_we_q    <= 1'b0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
    end else if (capture) begin
      h_we_q    <= bus.host_we;
      h_addr_q  <= bus.host_addr;
      h_wdata_q <= bus.host_wdata;
    end
  end

  // Out-of-range host accesses of either kind clear the read-back register; in-range writes hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rdata_q <= '0;
    end else if (h_go && (!h_we_q || !h_in)) begin
      host_rdata_q <= h_in ? mem[h_idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (bus.vram_r_ena && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (bus.vram_w_ena && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (err_set) addr_err_q <= 1'b1;
    end
  end

  // Host only writes while the core is idle, so the two write sources never collide.
  always_ff @(posedge clk) begin
    if (core_wr_go) begin
      mem[w_idx] <= (mem[w_idx] & ~bus.vram_w_mask) | (bus.vram_w_data & bus.vram_w_mask);
    end else if (host_wr_go) begin
      mem[h_idx] <= h_wdata_q;
    end
  end

endmodule

// File: tb/tb_v_vram_resp.sv
// Randomized scoreboard bench for v_vram_resp against a word-array reference model.
`timescale 1ns/1ps
module tb_v_vram_resp;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 64;
  localparam int DEPTH  = 1024;
  localparam int CNT_W  = 32;
  localparam int BYTES  = DATA_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  v_vram_resp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  v_vram_resp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mdl [DEPTH];
  logic [DATA_W-1:0] exp_rd [$];
  logic [DATA_W-1:0] exp_h  [$];
  int                rd_m;
  int                wr_m;
  bit                err_m;
  logic [DATA_W-1:0] h_rd_m;
  logic [DATA_W-1:0] ones;

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(logic [ADDR_W-1:0] a);
    return (a / BYTES) < DEPTH;
  endfunction

  function automatic int idx_of(logic [ADDR_W-1:0] a);
    return int'(a / BYTES);
  endfunction

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    logic [ADDR_W-1:0] a;
    if ($urandom_range(0, 19) == 0) begin
      a = {32'($urandom), 32'($urandom)};
      a[40] = 1'b1;
    end else begin
      a = ADDR_W'($urandom_range(0, 15) * BYTES + $urandom_range(0, BYTES - 1));
    end
    return a;
  endfunction

  // Scoreboard monitor: every presented core read and every host ack consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.vram_r_ena) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL core_rd_unexpected: got read with empty queue, want none");
        end else begin
          chk("core_rd", bus.vram_r_data, exp_rd.pop_front());
        end
      end
      if (bus.host_ack) begin
        if (exp_h.size() == 0) begin
          checks++; errors++;
          $display("FAIL host_ack_unexpected: got ack with empty queue, want none");
        end else begin
          chk("host_rdata", bus.host_rdata, exp_h.pop_front());
        end
      end
    end
  end

  // Called just after a rising edge; drives one core cycle and updates the model.
  task automatic core_cycle(bit re, logic [ADDR_W-1:0] ra, bit we, logic [ADDR_W-1:0] wa,
                            logic [DATA_W-1:0] wd, logic [DATA_W-1:0] wm);
    bus.vram_r_ena  = re;
    bus.vram_r_addr = ra;
    bus.vram_w_ena  = we;
    bus.vram_w_addr = wa;
    bus.vram_w_data = wd;
    bus.vram_w_mask = wm;
    if (re) begin
      exp_rd.push_back(in_rng(ra) ? mdl[idx_of(ra)] : '0);
      if (!in_rng(ra)) err_m = 1'b1;
      rd_m++;
    end
    if (we) begin
      if (in_rng(wa)) begin
        for (int b = 0; b < DATA_W; b++)
          if (wm[b]) mdl[idx_of(wa)][b] = wd[b];
      end else begin
        err_m = 1'b1;
      end
      wr_m++;
    end
    @(posedge clk); #1;
    bus.vram_r_ena = 1'b0;
    bus.vram_w_ena = 1'b0;
  endtask

  task automatic host_txn(bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd, output int ack_cyc);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = wd;
    if (in_rng(a)) begin
      if (we) mdl[idx_of(a)] = wd;
      else    h_rd_m = mdl[idx_of(a)];
    end else begin
      h_rd_m = '0;
      err_m  = 1'b1;
    end
    exp_h.push_back(h_rd_m);
    @(posedge clk); #1;
    bus.host_we    = ~we;
    bus.host_addr  = rnd_addr();
    bus.host_wdata = rnd_word();
    ack_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    checks++;
    if (ack_cyc < 0) begin
      errors++;
      $display("FAIL host_ack_timeout: got no ack in 64 cycles, want ack");
    end
    @(posedge clk); #1;
    chk("host_rdata_held", bus.host_rdata, h_rd_m);
    bus.host_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    rd_m   = 0;
    wr_m   = 0;
    err_m  = 1'b0;
    h_rd_m = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac;
    int n0;
    logic [DATA_W-1:0] pat;
    ones = '1;
    bus.vram_r_ena = 0; bus.vram_r_addr = '0; bus.vram_w_ena = 0; bus.vram_w_addr = '0;
    bus.vram_w_data = '0; bus.vram_w_mask = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_host_ack", DATA_W'(bus.host_ack), '0);
    chk("rst_host_rdata", bus.host_rdata, '0);
    chk("rst_rd_cnt", DATA_W'(bus.rd_cnt), '0);
    chk("rst_wr_cnt", DATA_W'(bus.wr_cnt), '0);
    chk("rst_addr_err", DATA_W'(bus.addr_err), '0);

    // Preload words 0..15 through the host port; word 3 gets the A5 pattern.
    for (int i = 0; i < 16; i++) begin
      pat = rnd_word();
      if (i == 3) pat = {64{8'hA5}};
      host_txn(1'b1, ADDR_W'(i * BYTES), pat, ac);
    end

    core_cycle(1'b1, ADDR_W'(3 * BYTES), 1'b0, '0, '0, '0);
    chk("t1_rd_cnt", DATA_W'(bus.rd_cnt), DATA_W'(1));
    chk("t1_a5_model", mdl[3], {64{8'hA5}});

    host_txn(1'b1, ADDR_W'(5 * BYTES), '0, ac);
    core_cycle(1'b0, '0, 1'b1, ADDR_W'(320), ones, DATA_W'(8'hFF));
    chk("t2_wr_cnt", DATA_W'(bus.wr_cnt), DATA_W'(1));
    chk("t2_mem5_model", mdl[5], DATA_W'(8'hFF));
    core_cycle(1'b1, ADDR_W'(5 * BYTES + 7), 1'b0, '0, '0, '0);

    // Host read stalls behind four back-to-back core reads.
    n0 = cyc;
    fork
      host_txn(1'b0, ADDR_W'(7 * BYTES), '0, ac);
      for (int i = 0; i < 4; i++) core_cycle(1'b1, ADDR_W'(i * BYTES), 1'b0, '0, '0, '0);
    join
    chk("t3_ack_cycle", DATA_W'(ac), DATA_W'(n0 + 5));

    host_txn(1'b1, ADDR_W'(2 * BYTES), '0, ac);
    core_cycle(1'b1, ADDR_W'(2 * BYTES), 1'b1, ADDR_W'(2 * BYTES), DATA_W'(1), ones);
    core_cycle(1'b1, ADDR_W'(2 * BYTES), 1'b0, '0, '0, '0);
    chk("t4_mem2_model", mdl[2], DATA_W'(1));

    chk("t5_err_before", DATA_W'(bus.addr_err), '0);
    core_cycle(1'b0, '0, 1'b1, ADDR_W'(DEPTH * BYTES), ones, ones);
    core_cycle(1'b1, ADDR_W'(DEPTH * BYTES), 1'b0, '0, '0, '0);
    core_cycle(1'b1, ADDR_W'(0), 1'b0, '0, '0, '0);
    repeat (5) @(posedge clk);
    #1 chk("t5_err_sticky", DATA_W'(bus.addr_err), DATA_W'(1));

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        host_txn(1'($urandom_range(0, 1)), rnd_addr(), rnd_word(), ac);
      end else begin
        core_cycle(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(),
                   rnd_word(), ($urandom_range(0, 3) == 0) ? ones : rnd_word());
      end
    end
    chk("rnd_rd_cnt", DATA_W'(bus.rd_cnt), DATA_W'(rd_m));
    chk("rnd_wr_cnt", DATA_W'(bus.wr_cnt), DATA_W'(wr_m));
    chk("rnd_addr_err", DATA_W'(bus.addr_err), DATA_W'(err_m));

    // Reset lands while the host request sits in REQ behind a core read.
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = ADDR_W'(4 * BYTES);
    core_cycle(1'b1, ADDR_W'(BYTES), 1'b0, '0, '0, '0);
    rst = 1'b1;
    bus.host_req = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_ack_in_rst", DATA_W'(bus.host_ack), '0);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_ack_after", DATA_W'(bus.host_ack), '0);
    end
    @(posedge clk); #1;
    chk("t6_rd_cnt", DATA_W'(bus.rd_cnt), '0);
    chk("t6_wr_cnt", DATA_W'(bus.wr_cnt), '0);
    chk("t6_addr_err", DATA_W'(bus.addr_err), '0);
    chk("t6_host_rdata", bus.host_rdata, '0);
    host_txn(1'b1, ADDR_W'(9 * BYTES), rnd_word(), ac);
    host_txn(1'b0, ADDR_W'(9 * BYTES), '0, ac);
    core_cycle(1'b1, ADDR_W'(3 * BYTES + 17), 1'b0, '0, '0, '0);
    chk("t6_rd_cnt_after", DATA_W'(bus.rd_cnt), DATA_W'(1));

    repeat (3) @(posedge clk);
    #1;
    chk("drain_rd_q", DATA_W'(exp_rd.size()), '0);
    chk("drain_host_q", DATA_W'(exp_h.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
